// File: rtl/shift_register_universal_if.sv
// Control/data bundle for shift_register_universal.
// The master drives the controls; the slave (the register) drives the results.
interface shift_register_universal_if #(
    parameter int WIDTH = 8
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic             load;
    logic [WIDTH-1:0] load_data;
    logic             shift_en;
    logic [2:0]       mode;
    logic             ser_in;
    logic             burst_start;
    logic [CNT_W-1:0] burst_len;
    logic [WIDTH-1:0] data_out;
    logic             ser_out;
    logic             busy;
    logic             done;

    modport master (
        output load, load_data, shift_en, mode, ser_in, burst_start, burst_len,
        input  data_out, ser_out, busy, done
    );

    modport slave (
        input  load, load_data, shift_en, mode, ser_in, burst_start, burst_len,
        output data_out, ser_out, busy, done
    );
endinterface

// File: rtl/shift_register_universal.sv
// Parametrised universal shift register with parallel load, six shift modes,
// registered serial-out and an autonomous burst engine (start/done handshake).
module shift_register_universal #(
    parameter int WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    shift_register_universal_if.slave    bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             ser_q, ser_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bmode_q, bmode_d;
    logic             done_q, done_d;

    // Returns {ser_out, data}; hold modes keep the previous serial bit.
    function automatic logic [WIDTH:0] shift_op(
        input logic [WIDTH-1:0] q,
        input logic [2:0]       m,
        input logic             si,
        input logic             so
    );
        case (m)
            3'd1:    shift_op = {q[WIDTH-1], q[WIDTH-2:0], si};
            3'd2:    shift_op = {q[0], si, q[WIDTH-1:1]};
            3'd3:    shift_op = {q[WIDTH-1], q[WIDTH-2:0], q[WIDTH-1]};
            3'd4:    shift_op = {q[0], q[0], q[WIDTH-1:1]};
            3'd5:    shift_op = {q[0], q[WIDTH-1], q[WIDTH-1:1]};
            default: shift_op = {so, q};
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        ser_d   = ser_q;
        cnt_d   = cnt_q;
        bmode_d = bmode_q;
        done_d  = 1'b0;

        if (bus.load) begin
            // Load also aborts a running burst without signalling done.
            data_d  = bus.load_data;
            state_d = IDLE;
            cnt_d   = '0;
        end else if (state_q == BUSY) begin
            {ser_d, data_d} = shift_op(data_q, bmode_q, bus.ser_in, ser_q);
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
        end else if (bus.burst_start) begin
            if (bus.burst_len == '0) begin
                done_d = 1'b1;
            end else begin
                state_d = BUSY;
                cnt_d   = bus.burst_len;
                bmode_d = bus.mode;
            end
        end else if (bus.shift_en) begin
            {ser_d, data_d} = shift_op(data_q, bus.mode, bus.ser_in, ser_q);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            data_q  <= '0;
            ser_q   <= 1'b0;
            cnt_q   <= '0;
            bmode_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            ser_q   <= ser_d;
            cnt_q   <= cnt_d;
            bmode_q <= bmode_d;
            done_q  <= done_d;
        end
    end

    assign bus.data_out = data_q;
    assign bus.ser_out  = ser_q;
    assign bus.busy     = (state_q == BUSY);
    assign bus.done     = done_q;
endmodule

// File: tb/tb_shift_register_universal.sv
// Scoreboard bench for shift_register_universal: stimulus pushes the expected
// post-edge state, a monitor pops and compares just after each rising edge.
module tb_shift_register_universal;
    localparam int WIDTH = 8;
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic clk = 1'b0;
    logic reset;

    shift_register_universal_if #(.WIDTH(WIDTH)) bus ();

    shift_register_universal #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string            name;
        logic [WIDTH+2:0] exp;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic compare(input string nm, input logic [WIDTH+2:0] exp);
        logic [WIDTH+2:0] act;
        act = {bus.data_out, bus.ser_out, bus.busy, bus.done};
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got data=%h ser=%b busy=%b done=%b, want data=%h ser=%b busy=%b done=%b",
                     nm, act[WIDTH+2:3], act[2], act[1], act[0],
                     exp[WIDTH+2:3], exp[2], exp[1], exp[0]);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            compare(mon_e.name, mon_e.exp);
        end
    end

    // Drive one cycle of inputs and queue the state expected after the next edge.
    task automatic cyc(input string nm, input logic ld, input logic [WIDTH-1:0] ldd,
                       input logic se, input logic [2:0] md, input logic si,
                       input logic bs, input logic [CNT_W-1:0] bl,
                       input logic [WIDTH-1:0] ed, input logic es, input logic eb,
                       input logic edn);
        @(negedge clk);
        bus.load        = ld;
        bus.load_data   = ldd;
        bus.shift_en    = se;
        bus.mode        = md;
        bus.ser_in      = si;
        bus.burst_start = bs;
        bus.burst_len   = bl;
        sb.push_back('{name: nm, exp: {ed, es, eb, edn}});
    endtask

    task automatic idle(input string nm, input logic si, input logic [WIDTH-1:0] ed,
                        input logic es, input logic eb, input logic edn);
        cyc(nm, 1'b0, '0, 1'b0, 3'd0, si, 1'b0, '0, ed, es, eb, edn);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.load = 0; bus.load_data = '0; bus.shift_en = 0; bus.mode = 3'd0;
        bus.ser_in = 0; bus.burst_start = 0; bus.burst_len = '0;
        reset = 1'b1;
        @(negedge clk);
        compare("reset_state", {8'h00, 1'b0, 1'b0, 1'b0});
        reset = 1'b0;

        // Manual shifts and loads
        cyc("load_a5",  1, 8'hA5, 0, 3'd0, 0, 0, 4'd0, 8'hA5, 0, 0, 0);
        cyc("shl",      0, 8'h00, 1, 3'd1, 1, 0, 4'd0, 8'h4B, 1, 0, 0);
        cyc("load_90",  1, 8'h90, 0, 3'd0, 0, 0, 4'd0, 8'h90, 1, 0, 0);
        cyc("shr",      0, 8'h00, 1, 3'd2, 0, 0, 4'd0, 8'h48, 0, 0, 0);
        cyc("reload90", 1, 8'h90, 0, 3'd0, 0, 0, 4'd0, 8'h90, 0, 0, 0);
        cyc("asr",      0, 8'h00, 1, 3'd5, 0, 0, 4'd0, 8'hC8, 0, 0, 0);
        cyc("load_01",  1, 8'h01, 0, 3'd0, 0, 0, 4'd0, 8'h01, 0, 0, 0);
        cyc("rotr",     0, 8'h00, 1, 3'd4, 0, 0, 4'd0, 8'h80, 1, 0, 0);
        cyc("hold6",    0, 8'h00, 1, 3'd6, 0, 0, 4'd0, 8'h80, 1, 0, 0);
        cyc("hold0",    0, 8'h00, 1, 3'd0, 1, 0, 4'd0, 8'h80, 1, 0, 0);
        cyc("hold7",    0, 8'h00, 1, 3'd7, 1, 0, 4'd0, 8'h80, 1, 0, 0);

        // ROTL burst of 3 with disturbing inputs, then back-to-back SHR burst
        cyc("load_81",  1, 8'h81, 0, 3'd0, 0, 0, 4'd0, 8'h81, 1, 0, 0);
        cyc("rotl_go",  0, 8'h00, 0, 3'd3, 0, 1, 4'd3, 8'h81, 1, 1, 0);
        cyc("rotl_s1",  0, 8'h00, 1, 3'd1, 1, 1, 4'd5, 8'h03, 1, 1, 0);
        cyc("rotl_s2",  0, 8'h00, 1, 3'd2, 1, 1, 4'd0, 8'h06, 0, 1, 0);
        cyc("rotl_s3",  0, 8'h00, 0, 3'd4, 0, 0, 4'd0, 8'h0C, 0, 0, 1);
        cyc("b2b_go",   0, 8'h00, 0, 3'd2, 1, 1, 4'd1, 8'h0C, 0, 1, 0);
        cyc("b2b_s1",   0, 8'h00, 0, 3'd0, 1, 0, 4'd0, 8'h86, 0, 0, 1);
        idle("b2b_end", 0, 8'h86, 0, 0, 0);

        // Zero-length burst beats shift_en; hold-mode burst still counts
        cyc("load_3c",  1, 8'h3C, 0, 3'd0, 0, 0, 4'd0, 8'h3C, 0, 0, 0);
        cyc("zero_go",  0, 8'h00, 1, 3'd1, 1, 1, 4'd0, 8'h3C, 0, 0, 1);
        idle("zero_end", 0, 8'h3C, 0, 0, 0);
        cyc("hold_go",  0, 8'h00, 0, 3'd0, 0, 1, 4'd2, 8'h3C, 0, 1, 0);
        idle("hold_s1", 1, 8'h3C, 0, 1, 0);
        idle("hold_s2", 1, 8'h3C, 0, 0, 1);

        // Abort a 5-long SHL burst with a load on the second busy cycle
        cyc("abort_go", 0, 8'h00, 0, 3'd1, 0, 1, 4'd5, 8'h3C, 0, 1, 0);
        idle("abort_s1", 0, 8'h78, 0, 1, 0);
        cyc("abort_ld", 1, 8'hFF, 0, 3'd0, 0, 0, 4'd0, 8'hFF, 0, 0, 0);
        idle("abort_q1", 0, 8'hFF, 0, 0, 0);
        idle("abort_q2", 0, 8'hFF, 0, 0, 0);
        idle("abort_q3", 0, 8'hFF, 0, 0, 0);

        // load outranks burst_start in IDLE
        cyc("ld_vs_bs", 1, 8'h55, 0, 3'd3, 0, 1, 4'd3, 8'h55, 0, 0, 0);
        idle("ld_vs_bs2", 0, 8'h55, 0, 0, 0);

        // Asynchronous reset between edges in the middle of a burst
        cyc("load_81b", 1, 8'h81, 0, 3'd0, 0, 0, 4'd0, 8'h81, 0, 0, 0);
        cyc("rst_go",   0, 8'h00, 0, 3'd3, 0, 1, 4'd4, 8'h81, 0, 1, 0);
        idle("rst_s1",  0, 8'h03, 1, 1, 0);
        @(negedge clk);
        #2 reset = 1'b1;
        #1 compare("async_reset", {8'h00, 1'b0, 1'b0, 1'b0});
        @(negedge clk);
        reset = 1'b0;
        idle("post_rst1", 0, 8'h00, 0, 0, 0);
        idle("post_rst2", 0, 8'h00, 0, 0, 0);
        idle("post_rst3", 0, 8'h00, 0, 0, 0);
        idle("post_rst4", 0, 8'h00, 0, 0, 0);

        @(negedge clk);
        @(negedge clk);
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d pending entries, want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
